blinds_ctrl: RTL

Parametrised, sequential window-blind controller. It quantises a light-intensity sample into one of 2^POS_W blind positions. A dwell filter suppresses flicker, and an optional hysteresis band rejects samples sitting on a band edge. The blind is driven toward the target one step at a time at a fixed motor rate. A manual mode allows a host to command the position directly. It sits between the light-sensor sampler and the blind motor driver.

---
 rtl/blinds_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/blinds_ctrl.sv
// Window-blind controller: quantises light intensity to a blind position, dwell-filters it and steps the motor toward it.
// Optional hysteresis band on level qualification is enabled with `define BLINDS_HYST_EN.
module blinds_ctrl #(
  parameter int IN_W        = 4,
  parameter int POS_W       = 2,
  parameter int DWELL       = 8,
  parameter int STEP_CYCLES = 4,
  parameter int HYST        = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             auto_en,
  input  logic [IN_W-1:0]  intensity,
  input  logic             manual_valid,
  input  logic [POS_W-1:0] manual_pos,
  output logic [POS_W-1:0] out,
  output logic [POS_W-1:0] target,
  output logic             moving
);

  localparam int DW    = $clog2(DWELL + 1);
  localparam int SW    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int LOW_W = IN_W - POS_W;
  localparam logic [POS_W-1:0] MAXP = '1;

  if (POS_W > IN_W || DWELL < 1 || STEP_CYCLES < 1 || HYST < 0) begin : g_cfg_err
    $error("blinds_ctrl: illegal parameter combination");
  end

  typedef enum logic {IDLE, STEP} state_t;

  state_t           state_q, state_d;
  logic [POS_W-1:0] out_q, out_d;
  logic [POS_W-1:0] target_q, target_d;
  logic [POS_W-1:0] cand_q, cand_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [SW-1:0]    scnt_q, scnt_d;

  logic [POS_W-1:0] top;
  logic [POS_W-1:0] lvl;
  logic             qual;
  logic             lvl_same;
  logic [DW-1:0]    cnt_nx;

  assign top = intensity[IN_W-1 -: POS_W];
  assign lvl = MAXP - top;

`ifdef BLINDS_HYST_EN
  // A new level only qualifies when the sample sits HYST codes inside its band;
  // the extreme codes have no neighbour band and always qualify.
  always_comb begin
    int v, lo, hi;
    v    = int'(intensity);
    lo   = int'(top) << LOW_W;
    hi   = lo + (1 << LOW_W) - 1;
    qual = (v == 0) || (v == (2**IN_W) - 1) || ((v >= lo + HYST) && (v <= hi - HYST));
  end
`else
  logic unused_lsbs;
  assign unused_lsbs = ^intensity;
  assign qual        = 1'b1;
`endif

  assign lvl_same = (lvl == target_q) || !qual;

  // Target selection: dwell filter in auto mode, strobe load in manual mode.
  always_comb begin
    cand_d   = cand_q;
    dcnt_d   = dcnt_q;
    target_d = target_q;
    cnt_nx   = '0;
    if (!auto_en) begin
      dcnt_d = '0;
      if (manual_valid) target_d = manual_pos;
    end else if (lvl_same) begin
      dcnt_d = '0;
    end else begin
      cnt_nx = (lvl != cand_q) ? DW'(1) : dcnt_q + DW'(1);
      cand_d = lvl;
      if (cnt_nx == DW'(DWELL)) begin
        target_d = lvl;
        dcnt_d   = '0;
      end else begin
        dcnt_d = cnt_nx;
      end
    end
  end

  // Motor: step on the registered target so a same-edge retarget lands next cycle.
  // state_q lags the out/target mismatch by one edge and drives moving.
  always_comb begin
    out_d   = out_q;
    scnt_d  = '0;
    state_d = IDLE;
    if (out_q != target_q) begin
      state_d = STEP;
      if (scnt_q == SW'(STEP_CYCLES - 1)) begin
        out_d  = (target_q > out_q) ? out_q + 1'b1 : out_q - 1'b1;
        scnt_d = '0;
      end else begin
        scnt_d = scnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      out_q    <= '0;
      target_q <= '0;
      cand_q   <= '0;
      dcnt_q   <= '0;
      scnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      target_q <= target_d;
      cand_q   <= cand_d;
      dcnt_q   <= dcnt_d;
      scnt_q   <= scnt_d;
    end
  end

  assign out    = out_q;
  assign target = target_q;
  assign moving = (state_q == STEP);

endmodule
